// File: rtl/line_matrix_pkg.sv
// line_matrix_pkg: shared constants, commit FSM state type and width helper for line_matrix_router
package line_matrix_pkg;
  localparam int SRC_CONST0 = 0;
  localparam int SRC_CONST1 = 1;
  typedef enum logic {IDLE, COMMIT} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/line_matrix_deglitch.sv
// line_matrix_deglitch: one output's stability filter, instantiated per output when LINE_MATRIX_DEGLITCH_EN is defined
module line_matrix_deglitch #(
  parameter int DEGLITCH_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic q
);
  logic [7:0] cnt_q, cnt_d;
  logic q_q, q_d, differ, hit;
  assign differ = d != q_q;
  assign hit = !clr && differ && cnt_q == 8'(DEGLITCH_CYCLES - 1);
  // q takes d only after d has disagreed with q for DEGLITCH_CYCLES consecutive samples
  always_comb begin
    q_d = hit ? d : q_q;
    cnt_d = (clr || !differ || hit) ? 8'd0 : cnt_q + 8'd1;
  end
  // filter state
  always_ff @(posedge clk)
    if (rst) begin
      q_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      q_q <= q_d;
      cnt_q <= cnt_d;
    end
  assign q = q_q;
endmodule

// File: rtl/line_matrix_router.sv
// line_matrix_router: routes synchronised input lines or constants to output pins via shadow/active tables; optional deglitch under LINE_MATRIX_DEGLITCH_EN
module line_matrix_router import line_matrix_pkg::*; #(
  parameter int NUM_INPUTS = 8,
  parameter int NUM_OUTPUTS = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DEGLITCH_CYCLES = 4,
  localparam int OUT_W = clog2(NUM_OUTPUTS) > 1 ? clog2(NUM_OUTPUTS) : 1,
  localparam int SRC_W = clog2(NUM_INPUTS + 2)
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_INPUTS-1:0] input_lines,
  output logic [NUM_OUTPUTS-1:0] output_lines,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [OUT_W-1:0] cfg_output,
  input  logic [SRC_W-1:0] cfg_source,
  input  logic cfg_commit,
  output logic cfg_err,
  output logic commit_done,
  input  logic [OUT_W-1:0] rb_output,
  output logic [SRC_W-1:0] rb_source
);
  localparam logic [SRC_W-1:0] SRC_ZERO = SRC_W'(NUM_INPUTS + SRC_CONST0);
  if (NUM_INPUTS < 1 || NUM_INPUTS > 64 || NUM_OUTPUTS < 1 || NUM_OUTPUTS > 64 ||
      SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEGLITCH_CYCLES < 1 || DEGLITCH_CYCLES > 255) begin : g_bad_param
    $error("line_matrix_router: parameter out of range");
  end
  logic [SYNC_STAGES-1:0][NUM_INPUTS-1:0] sync_q;
  logic [SRC_W-1:0] shadow_q [NUM_OUTPUTS];
  logic [SRC_W-1:0] active_q [NUM_OUTPUTS];
  logic [NUM_INPUTS+1:0] src_v;
  logic [NUM_OUTPUTS-1:0] mux_v, out_d, out_q;
  logic [SRC_W-1:0] rb_q;
  state_t state_q;
  logic ready_q, err_q, done_q, wr, bad, start;
  // source codes above the inputs select constant 0 then constant 1
  assign src_v = {1'b1, 1'b0, sync_q[SYNC_STAGES-1]};
  assign wr = cfg_valid && ready_q;
  assign bad = {1'b0, cfg_output} >= (OUT_W+1)'(NUM_OUTPUTS) ||
               {1'b0, cfg_source} > (SRC_W+1)'(NUM_INPUTS + SRC_CONST1);
  assign start = state_q == IDLE && cfg_commit;
  // input synchroniser chain
  always_ff @(posedge clk)
    sync_q <= rst ? '0 : {sync_q[SYNC_STAGES-2:0], input_lines};
  // per-output source select from the active table
  always_comb begin
    mux_v = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) mux_v[k] = src_v[active_q[k]];
  end
  // route tables, commit FSM and registered status outputs
  always_ff @(posedge clk)
    if (rst) begin
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        shadow_q[k] <= SRC_ZERO;
        active_q[k] <= SRC_ZERO;
      end
      state_q <= IDLE;
      ready_q <= 1'b1;
      err_q <= 1'b0;
      done_q <= 1'b0;
      rb_q <= SRC_ZERO;
    end else begin
      if (wr && !bad) shadow_q[cfg_output] <= cfg_source;
      if (state_q == COMMIT) active_q <= shadow_q;
      err_q <= wr && bad;
      done_q <= state_q == COMMIT;
      state_q <= start ? COMMIT : IDLE;
      ready_q <= !start;
      rb_q <= ({1'b0, rb_output} < (OUT_W+1)'(NUM_OUTPUTS)) ? active_q[rb_output] : SRC_ZERO;
    end
`ifdef LINE_MATRIX_DEGLITCH_EN
  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_dg
    line_matrix_deglitch #(.DEGLITCH_CYCLES(DEGLITCH_CYCLES)) u_dg (
      .clk(clk),
      .rst(rst),
      .clr(state_q == COMMIT),
      .d(mux_v[k]),
      .q(out_d[k])
    );
  end
`else
  assign out_d = mux_v;
`endif
  // registered output pins
  always_ff @(posedge clk)
    out_q <= rst ? '0 : out_d;
  assign output_lines = out_q;
  assign cfg_ready = ready_q;
  assign cfg_err = err_q;
  assign commit_done = done_q;
  assign rb_source = rb_q;
endmodule

// File: tb/tb_line_matrix_router.sv
// tb_line_matrix_router: directed and randomized checks of line_matrix_router against a behavioural model
module tb_line_matrix_router;
  localparam int NI = 8;
  localparam int NO = 10;
  localparam int SS = 2;
  localparam int OW = 4;
  localparam int SW = 4;
  logic clk = 0, rst = 1;
  logic [NI-1:0] input_lines = '0;
  logic [NO-1:0] output_lines;
  logic cfg_valid = 0, cfg_ready, cfg_commit = 0, cfg_err, commit_done;
  logic [OW-1:0] cfg_output = '0, rb_output = '0;
  logic [SW-1:0] cfg_source = '0, rb_source;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  line_matrix_router dut (
    .clk(clk), .rst(rst), .input_lines(input_lines), .output_lines(output_lines),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_output(cfg_output), .cfg_source(cfg_source),
    .cfg_commit(cfg_commit), .cfg_err(cfg_err), .commit_done(commit_done),
    .rb_output(rb_output), .rb_source(rb_source)
  );

  // behavioural model: route tables as int arrays, pins delayed by the synchroniser depth
  int m_shadow[NO], m_active[NO];
  logic [NI-1:0] m_pins[SS];
  bit m_pend, busy;
  logic [NO-1:0] exp_out = '0;
  bit exp_err = 0, exp_done = 0, exp_ready = 0;
  int exp_rb = NI;

  function automatic bit route(input int src, input logic [NI-1:0] p);
    return src < NI ? ((p >> src) & NI'(1)) != 0 : src == NI + 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NO; i++) begin
        m_shadow[i] = NI;
        m_active[i] = NI;
      end
      for (int i = 0; i < SS; i++) m_pins[i] = '0;
      m_pend = 0;
      exp_out = '0;
      exp_err = 0;
      exp_done = 0;
      exp_rb = NI;
    end else begin
      for (int k = 0; k < NO; k++) exp_out[k] = route(m_active[k], m_pins[SS-1]);
      exp_rb = int'(rb_output) < NO ? m_active[int'(rb_output)] : NI;
      exp_done = m_pend;
      exp_err = 0;
      busy = m_pend;
      if (busy) m_active = m_shadow;
      if (cfg_valid && !busy) begin
        if (int'(cfg_output) >= NO || int'(cfg_source) > NI + 1) exp_err = 1;
        else m_shadow[int'(cfg_output)] = int'(cfg_source);
      end
      m_pend = !busy && cfg_commit;
      for (int s = SS - 1; s > 0; s--) m_pins[s] = m_pins[s-1];
      m_pins[0] = input_lines;
    end
    exp_ready = !m_pend;
  end

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    tests++;
    if (output_lines !== '0 || cfg_err !== 1'b0 || commit_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_outs got out=%h err=%b done=%b want 0", output_lines, cfg_err, commit_done);
    end
    rst = 0;
    input_lines = '1;
    for (int i = 0; i <= NO; i++) begin
      rb_output = OW'(i);
      @(negedge clk);
      tests++;
      if (rb_source !== SW'(NI)) begin
        fails++;
        $display("FAIL reset_rb idx=%0d got %0d want %0d", i, rb_source, NI);
      end
      tests++;
      if (output_lines !== '0) begin
        fails++;
        $display("FAIL reset_out got %h want 0", output_lines);
      end
      tests++;
      if (cfg_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_ready got %b want 1", cfg_ready);
      end
    end
  endtask

  task automatic test_route_commit;
    int n;
    cfg_valid = 1; cfg_output = 3; cfg_source = 5;
    @(negedge clk);
    cfg_valid = 0;
    tests++;
    if (cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL route_err got %b want 0", cfg_err);
    end
    for (int c = 0; c < 6; c++) begin
      input_lines[5] = ~input_lines[5];
      @(negedge clk);
      tests++;
      if (output_lines[3] !== 1'b0) begin
        fails++;
        $display("FAIL nocommit_out3 got %b want 0", output_lines[3]);
      end
    end
    cfg_commit = 1;
    @(negedge clk);
    cfg_commit = 0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      if (commit_done === 1'b1) n++;
      @(negedge clk);
    end
    tests++;
    if (n != 1) begin
      fails++;
      $display("FAIL commit_done_pulses got %0d want 1", n);
    end
    input_lines[5] = 0;
    repeat (4) @(negedge clk);
    tests++;
    if (output_lines[3] !== 1'b0) begin
      fails++;
      $display("FAIL settle_out3 got %b want 0", output_lines[3]);
    end
    input_lines[5] = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tests++;
      if (output_lines[3] !== (c == 3)) begin
        fails++;
        $display("FAIL latency_out3 cycle=%0d got %b want %b", c, output_lines[3], c == 3);
      end
    end
  endtask

  task automatic test_same_cycle;
    tests++;
    if (cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL same_ready_before got %b want 1", cfg_ready);
    end
    cfg_valid = 1; cfg_output = 0; cfg_source = 9; cfg_commit = 1;
    @(negedge clk);
    cfg_valid = 0; cfg_commit = 0;
    for (int c = 1; c <= 3; c++) begin
      tests++;
      if (cfg_ready !== (c != 1)) begin
        fails++;
        $display("FAIL same_ready cycle=%0d got %b want %b", c, cfg_ready, c != 1);
      end
      tests++;
      if (output_lines[0] !== (c == 3)) begin
        fails++;
        $display("FAIL same_out0 cycle=%0d got %b want %b", c, output_lines[0], c == 3);
      end
      if (c < 3) @(negedge clk);
    end
  endtask

  task automatic test_errors;
    int want;
    logic [OW-1:0] bo [3] = '{OW'(10), OW'(2), OW'(15)};
    logic [SW-1:0] bs [3] = '{SW'(1), SW'(12), SW'(9)};
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1; cfg_output = bo[i]; cfg_source = bs[i];
      @(negedge clk);
      cfg_valid = 0;
      tests++;
      if (cfg_err !== 1'b1) begin
        fails++;
        $display("FAIL err_pulse case=%0d got %b want 1", i, cfg_err);
      end
      @(negedge clk);
      tests++;
      if (cfg_err !== 1'b0) begin
        fails++;
        $display("FAIL err_clear case=%0d got %b want 0", i, cfg_err);
      end
    end
    cfg_commit = 1;
    @(negedge clk);
    cfg_commit = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NO; i++) begin
      rb_output = OW'(i);
      @(negedge clk);
      want = i == 0 ? 9 : i == 3 ? 5 : NI;
      tests++;
      if (rb_source !== SW'(want)) begin
        fails++;
        $display("FAIL err_rb idx=%0d got %0d want %0d", i, rb_source, want);
      end
    end
  endtask

  task automatic test_reset_mid_commit;
    cfg_valid = 1; cfg_output = 1; cfg_source = 9;
    @(negedge clk);
    cfg_output = 2; cfg_source = 1;
    @(negedge clk);
    cfg_valid = 0; cfg_commit = 1;
    @(negedge clk);
    cfg_commit = 0; rst = 1;
    @(negedge clk);
    rst = 0; input_lines = '1;
    for (int i = 0; i < NO; i++) begin
      rb_output = OW'(i);
      @(negedge clk);
      tests++;
      if (rb_source !== SW'(NI)) begin
        fails++;
        $display("FAIL midrst_rb idx=%0d got %0d want %0d", i, rb_source, NI);
      end
      tests++;
      if (output_lines !== '0) begin
        fails++;
        $display("FAIL midrst_out got %h want 0", output_lines);
      end
    end
    cfg_commit = 1;
    @(negedge clk);
    cfg_commit = 0;
    rb_output = 1;
    repeat (3) @(negedge clk);
    tests++;
    if (rb_source !== SW'(NI) || output_lines !== '0) begin
      fails++;
      $display("FAIL midrst_recommit got rb=%0d out=%h want rb=%0d out=0", rb_source, output_lines, NI);
    end
  endtask

  task automatic test_random;
    bit rdy_prev = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      tests++;
      if (output_lines !== exp_out) begin
        fails++;
        $display("FAIL rnd_out cycle=%0d got %h want %h", c, output_lines, exp_out);
      end
      tests++;
      if (cfg_ready !== exp_ready || cfg_err !== exp_err || commit_done !== exp_done) begin
        fails++;
        $display("FAIL rnd_status cycle=%0d got rdy=%b err=%b done=%b want rdy=%b err=%b done=%b",
                 c, cfg_ready, cfg_err, commit_done, exp_ready, exp_err, exp_done);
      end
      tests++;
      if (rb_source !== SW'(exp_rb)) begin
        fails++;
        $display("FAIL rnd_rb cycle=%0d got %0d want %0d", c, rb_source, exp_rb);
      end
      input_lines = NI'($urandom);
      rb_output = OW'($urandom_range(0, 11));
      cfg_commit = $urandom_range(0, 7) == 0;
      if (!cfg_valid || rdy_prev) begin
        cfg_valid = $urandom_range(0, 2) == 0;
        cfg_output = OW'($urandom_range(0, 10));
        cfg_source = SW'($urandom_range(0, 10));
      end
      rdy_prev = exp_ready;
    end
    cfg_valid = 0;
    cfg_commit = 0;
    @(negedge clk);
  endtask

  task automatic test_deglitch;
    int len [3] = '{2, 3, 4};
    cfg_valid = 1; cfg_output = 3; cfg_source = 5; cfg_commit = 1;
    input_lines = '0;
    @(negedge clk);
    cfg_valid = 0; cfg_commit = 0;
    repeat (12) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      input_lines[5] = 1;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (c == len[p]) input_lines[5] = 0;
        if (c == 6 || c == 7) begin
          tests++;
          if (output_lines[3] !== (len[p] == 4 && c == 7)) begin
            fails++;
            $display("FAIL dg_out3 len=%0d cycle=%0d got %b want %b", len[p], c, output_lines[3], len[p] == 4 && c == 7);
          end
        end
      end
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
`ifdef LINE_MATRIX_DEGLITCH_EN
    test_deglitch;
`else
    test_route_commit;
    test_same_cycle;
    test_errors;
    test_reset_mid_commit;
    test_random;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
